// File: rtl/ktc32_loader_pkg.sv
// rtl/ktc32_loader_pkg.sv - shared types and helpers for the UART program loader
package ktc32_loader_pkg;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  typedef enum logic [2:0] {L_CNT_LO, L_CNT_HI, L_DATA, L_DONE, L_ERR} ld_state_t;

  localparam int CNT_WIDTH = 16;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with input synchronizer, byte and framing-error strobes
module uart_rx
  import ktc32_loader_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  rx_state_t     state, state_d;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
    end
  end

  always_comb begin
    state_d         = state;
    cnt_d           = cnt + CW'(1);
    bit_idx_d       = bit_idx;
    shreg_d         = shreg;
    byte_valid      = 1'b0;
    frame_err_pulse = 1'b0;
    case (state)
      R_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = R_START;
      end
      R_START: begin
        // A start bit that is gone by mid-bit was a glitch, not a frame.
        if (cnt == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_d = R_STOP;
          else bit_idx_d = bit_idx + 3'd1;
        end
      end
      R_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (rx_s) byte_valid = 1'b1;
          else frame_err_pulse = 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART program download into instruction RAM, holds CPU in reset until loaded
module uart_loader
  import ktc32_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err
);

  logic       byte_valid, frame_err_pulse;
  logic [7:0] byte_data;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .frame_err_pulse (frame_err_pulse)
  );

  ld_state_t             state, state_d;
  logic [CNT_WIDTH-1:0]  n, n_d, widx, widx_d;
  logic [1:0]            bidx, bidx_d;
  logic [23:0]           word, word_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [31:0]           mem_wdata_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= L_CNT_LO;
      n         <= '0;
      widx      <= '0;
      bidx      <= '0;
      word      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      n         <= n_d;
      widx      <= widx_d;
      bidx      <= bidx_d;
      word      <= word_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state;
    n_d         = n;
    widx_d      = widx;
    bidx_d      = bidx;
    word_d      = word;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if (frame_err_pulse && state != L_ERR) begin
      state_d = L_ERR;
    end else if (byte_valid) begin
      case (state)
        L_CNT_LO: begin
          n_d     = {n[15:8], byte_data};
          state_d = L_CNT_HI;
        end
        L_CNT_HI: begin
          n_d     = {byte_data, n[7:0]};
          widx_d  = '0;
          bidx_d  = '0;
          state_d = ({byte_data, n[7:0]} == '0) ? L_DONE : L_DATA;
        end
        L_DATA: begin
          // Bytes arrive LSB first, so shifting right leaves them in place after the fourth.
          if (bidx == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = widx[ADDR_WIDTH-1:0];
            mem_wdata_d = {byte_data, word};
            widx_d      = widx + CNT_WIDTH'(1);
            bidx_d      = '0;
            if (widx == n - CNT_WIDTH'(1)) state_d = L_DONE;
          end else begin
            word_d = {byte_data, word[23:8]};
            bidx_d = bidx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == L_CNT_HI) || (state == L_DATA);
  assign done        = (state == L_DONE);
  assign cpu_reset_n = (state == L_DONE);
  assign frame_err   = (state == L_ERR);

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - self-checking bench for uart_loader against a byte-level protocol model
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset_n, busy, done, frame_err;

  uart_loader #(.CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .done        (done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          start;
  } wr_t;
  wr_t expq[$];

  int          wr_count = 0;
  logic [3:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  // phase: 0 count-lo, 1 count-hi, 2 data, 3 done, 4 error
  int          m_phase, m_n, m_widx, m_bi;
  logic [31:0] m_word;
  int          byte_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_widx = 0; m_bi = 0; m_word = 0;
    last_addr = '0; last_data = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (m_phase == 4) return;
    if (!ok) begin
      m_phase = 4;
      return;
    end
    case (m_phase)
      0: begin m_n = b; m_phase = 1; end
      1: begin
        m_n = m_n + 256 * b;
        m_widx = 0; m_bi = 0; m_word = 0;
        m_phase = (m_n == 0) ? 3 : 2;
      end
      2: begin
        m_word = m_word | (32'(b) << (8 * m_bi));
        m_bi++;
        if (m_bi == 4) begin
          expq.push_back('{4'(m_widx % 16), m_word, byte_start});
          m_widx++; m_bi = 0; m_word = 0;
          if (m_widx == m_n) m_phase = 3;
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      if (mem_we) begin
        wr_count++;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_wdata);
        end else begin
          e = expq.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
          checks++;
          if (cyc < e.start + 92 || cyc > e.start + 102) begin
            errors++;
            $display("FAIL wr_time: write at cycle %0d, byte started %0d, required within stop bit", cyc, e.start);
          end
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        check("hold_addr", mem_addr, last_addr);
        check("hold_data", mem_wdata, last_data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(posedge clk); #1;
    byte_start = cyc;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (10) @(posedge clk);
    end
    #1 rx = stop_ok;
    model_byte(b, stop_ok);
    repeat (10) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_count(input logic [15:0] cnt);
    send_byte(cnt[7:0], 1'b1);
    send_byte(cnt[15:8], 1'b1);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, busy, (m_phase == 1 || m_phase == 2));
    check({tag, "_done"}, done, (m_phase == 3));
    check({tag, "_cpu_reset_n"}, cpu_reset_n, (m_phase == 3));
    check({tag, "_frame_err"}, frame_err, (m_phase == 4));
  endtask

  task automatic do_reset();
    check("pending_writes", expq.size(), 0);
    @(posedge clk); #1 reset = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    model_reset();
    expq.delete();
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 4'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_reset_n", cpu_reset_n, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    reset = 1'b1;
  endtask

  int wc;

  initial begin
    model_reset();
    do_reset();

    // two-word load
    send_count(16'd2);
    check_status("hdr2");
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    repeat (5) @(posedge clk); #1;
    check_status("load2");
    check("load2_addr", mem_addr, 4'h1);
    check("load2_data", mem_wdata, 32'hDEADBEEF);
    check("load2_writes", wr_count, 2);
    check("load2_done", done, 1'b1);

    // empty load, trailing byte ignored
    do_reset();
    wc = wr_count;
    send_count(16'd0);
    check_status("zero");
    send_byte(8'hAA, 1'b1);
    repeat (20) @(posedge clk); #1;
    check_status("zero_tail");
    check("zero_cpu_reset_n", cpu_reset_n, 1'b1);
    check("zero_writes", wr_count, wc);

    // short glitch while idle, then a one-word load
    do_reset();
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk); #1 rx = 1'b1;
    repeat (30) @(posedge clk); #1;
    check_status("glitch");
    check("glitch_busy", busy, 1'b0);
    send_count(16'd1);
    send_word(32'hCAFEF00D);
    repeat (5) @(posedge clk); #1;
    check_status("glitch_load");
    check("glitch_load_data", mem_wdata, 32'hCAFEF00D);

    // framing error mid-word
    do_reset();
    wc = wr_count;
    send_count(16'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (20) @(posedge clk); #1;
    check_status("ferr");
    check("ferr_flag", frame_err, 1'b1);
    check("ferr_cpu_reset_n", cpu_reset_n, 1'b0);
    check("ferr_writes", wr_count, wc);
    do_reset();
    send_count(16'd1);
    send_word(32'h0BADC0DE);
    repeat (5) @(posedge clk); #1;
    check_status("ferr_reload");
    check("ferr_reload_data", mem_wdata, 32'h0BADC0DE);

    // 17 words wrap the 4-bit address
    do_reset();
    send_count(16'd17);
    for (int i = 0; i < 17; i++) send_word(32'(i));
    repeat (5) @(posedge clk); #1;
    check_status("wrap");
    check("wrap_addr", mem_addr, 4'h0);
    check("wrap_data", mem_wdata, 32'h00000010);

    // reset in the middle of a word discards it
    do_reset();
    send_count(16'd3);
    send_word(32'h44332211);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    m_phase = 0;
    expq.delete();
    do_reset();
    wc = wr_count;
    send_count(16'd1);
    send_word(32'hA5A5A5A5);
    repeat (5) @(posedge clk); #1;
    check_status("midrst");
    check("midrst_addr", mem_addr, 4'h0);
    check("midrst_data", mem_wdata, 32'hA5A5A5A5);
    check("midrst_writes", wr_count, wc + 1);

    check("final_pending", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
